// File: rtl/control_sequencer.sv
// control_sequencer: T-state microsequencer for a small accumulator CPU.
// Steps IDLE -> T1..T6 per instruction (T1-T3 fetch, T4-T6 execute) and
// decodes bus/load strobes combinationally from the current T-state and opcode.
// Optional feature: define CTRL_SUB_EN to decode SUB (0x2) as ADD with alu_op=0001.
module control_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] ir_opcode,
  output logic       pc_send,
  output logic       pc_inc,
  output logic       mar_load,
  output logic       mem_send,
  output logic       ir_load,
  output logic       ir_send,
  output logic       a_load,
  output logic       a_send,
  output logic       b_load,
  output logic       alu_send,
  output logic [3:0] alu_op,
  output logic       out_load,
  output logic       halted
);

  localparam logic [3:0] OpLda = 4'h0;
  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpSub = 4'h2;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [2:0] {
    StIdle, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
  } state_e;

  state_e state_q;

  logic is_lda;
  logic is_out;
  logic is_alu;    // ADD, or SUB when enabled: same bus pattern, different alu_op
  logic is_sub;

  assign is_lda = (ir_opcode == OpLda);
  assign is_out = (ir_opcode == OpOut);
`ifdef CTRL_SUB_EN
  assign is_sub = (ir_opcode == OpSub);
`else
  assign is_sub = 1'b0;
`endif
  assign is_alu = (ir_opcode == OpAdd) || is_sub;

  // State register: advance one T-state per clock; HALT is left only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_q <= run ? StT1 : StIdle;
        StT1:    state_q <= StT2;
        StT2:    state_q <= StT3;
        StT3:    state_q <= StT4;
        StT4:    state_q <= (ir_opcode == OpHlt) ? StHalt : StT5;
        StT5:    state_q <= StT6;
        StT6:    state_q <= run ? StT1 : StIdle;
        StHalt:  state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output decode: Moore per T-state, qualified by opcode during execute.
  always_comb begin
    pc_send  = 1'b0;
    pc_inc   = 1'b0;
    mar_load = 1'b0;
    mem_send = 1'b0;
    ir_load  = 1'b0;
    ir_send  = 1'b0;
    a_load   = 1'b0;
    a_send   = 1'b0;
    b_load   = 1'b0;
    alu_send = 1'b0;
    alu_op   = 4'b0000;
    out_load = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      StT1: begin
        pc_send  = 1'b1;
        mar_load = 1'b1;
      end
      StT2: pc_inc = 1'b1;
      StT3: begin
        mem_send = 1'b1;
        ir_load  = 1'b1;
      end
      StT4: begin
        if (is_lda || is_alu) begin
          ir_send  = 1'b1;
          mar_load = 1'b1;
        end else if (is_out) begin
          a_send   = 1'b1;
          out_load = 1'b1;
        end
      end
      StT5: begin
        if (is_lda) begin
          mem_send = 1'b1;
          a_load   = 1'b1;
        end else if (is_alu) begin
          mem_send = 1'b1;
          b_load   = 1'b1;
        end
      end
      StT6: begin
        if (is_alu) begin
          alu_send = 1'b1;
          a_load   = 1'b1;
          alu_op   = is_sub ? 4'b0001 : 4'b0000;
        end
      end
      StHalt: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed scenarios plus random run/opcode traffic,
// checked every cycle against a T-step reference model with table-driven outputs.
module tb_control_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] ir_opcode;
  logic       pc_send, pc_inc, mar_load, mem_send, ir_load, ir_send;
  logic       a_load, a_send, b_load, alu_send, out_load, halted;
  logic [3:0] alu_op;

  control_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .ir_opcode (ir_opcode),
    .pc_send   (pc_send),
    .pc_inc    (pc_inc),
    .mar_load  (mar_load),
    .mem_send  (mem_send),
    .ir_load   (ir_load),
    .ir_send   (ir_send),
    .a_load    (a_load),
    .a_send    (a_send),
    .b_load    (b_load),
    .alu_send  (alu_send),
    .alu_op    (alu_op),
    .out_load  (out_load),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CTRL_SUB_EN
  localparam bit SubEn = 1'b1;
`else
  localparam bit SubEn = 1'b0;
`endif

  // Output vector layout: 12 strobe bits then alu_op.
  localparam logic [15:0] PCS = 16'h8000;
  localparam logic [15:0] PCI = 16'h4000;
  localparam logic [15:0] MAR = 16'h2000;
  localparam logic [15:0] MEM = 16'h1000;
  localparam logic [15:0] IRL = 16'h0800;
  localparam logic [15:0] IRS = 16'h0400;
  localparam logic [15:0] AL  = 16'h0200;
  localparam logic [15:0] AS  = 16'h0100;
  localparam logic [15:0] BL  = 16'h0080;
  localparam logic [15:0] ALS = 16'h0040;
  localparam logic [15:0] OUL = 16'h0020;
  localparam logic [15:0] HLT = 16'h0010;

  logic [15:0] obs;
  assign obs = {pc_send, pc_inc, mar_load, mem_send, ir_load, ir_send, a_load, a_send,
                b_load, alu_send, out_load, halted, alu_op};

  int n_cmp = 0;
  int n_bad = 0;
  // Model position: 0 = idle, 1..6 = T-step within instruction, 7 = halted.
  int m_step = 0;

  function automatic logic [15:0] expect_out(input int s, input logic [3:0] op);
    logic [15:0] v;
    bit alu_like;
    alu_like = (op == 4'h1) || (SubEn && op == 4'h2);
    v = 16'h0000;
    case (s)
      1: v = PCS | MAR;
      2: v = PCI;
      3: v = MEM | IRL;
      4: if (op == 4'h0 || alu_like) v = IRS | MAR;
         else if (op == 4'hE) v = AS | OUL;
      5: if (op == 4'h0) v = MEM | AL;
         else if (alu_like) v = MEM | BL;
      6: if (alu_like) v = ALS | AL | ((op == 4'h2) ? 16'h0001 : 16'h0000);
      7: v = HLT;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  function automatic int next_step(input int s, input logic r, input logic [3:0] op);
    if (s == 7) return 7;
    if (s == 0 || s == 6) return r ? 1 : 0;
    if (s == 4 && op == 4'hF) return 7;
    return s + 1;
  endfunction

  task automatic check(input string tag);
    logic [15:0] e;
    logic [4:0]  sends;
    e = expect_out(m_step, ir_opcode);
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (step %0d op %h)", tag, obs, e, m_step,
             ir_opcode);
    end
    sends = {pc_send, mem_send, ir_send, a_send, alu_send};
    n_cmp++;
    assert ($onehot0(sends) === 1'b1) else begin
      n_bad++;
      $error("FAIL %s_send_onehot: observed %b expected at most one set", tag, sends);
    end
  endtask

  // Drive inputs just after a rising edge, check mid-cycle, then advance the model.
  task automatic step(input logic r, input logic [3:0] op, input string tag);
    run = r;
    ir_opcode = op;
    @(negedge clk);
    check(tag);
    @(posedge clk);
    m_step = next_step(m_step, r, op);
    #1;
  endtask

  task automatic do_reset(input logic r);
    run = r;
    rst_n = 1'b0;
    m_step = 0;
    #2;
    check("in_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    run = 1'b0;
    ir_opcode = 4'h0;
    #3;

    // Reset with run held high: idle until the first edge, then T1.
    do_reset(1'b1);
    step(1'b1, 4'h1, "idle_after_reset");
    n_cmp++;
    assert ((pc_send && mar_load) === 1'b1) else begin
      n_bad++;
      $error("FAIL t1_first_edge: observed pc_send=%b mar_load=%b expected 1 1",
             pc_send, mar_load);
    end

    // ADD: six steps, then next instruction's T1.
    for (int i = 0; i < 7; i++) step(1'b1, 4'h1, "add_seq");

    // LDA with run dropped in T3: finish T4-T6, then park in idle.
    do_reset(1'b0);
    step(1'b1, 4'h0, "lda_t0");
    step(1'b1, 4'h0, "lda_t1");
    step(1'b1, 4'h0, "lda_t2");
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, "lda_rundrop");
    step(1'b0, 4'h0, "lda_parked");

    // OUT instruction.
    for (int i = 0; i < 7; i++) step(1'b1, 4'hE, "out_seq");

    // SUB / opcode 0x2 (NOP unless SUB enabled), then an undefined opcode.
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 4'h2, "op2_seq");
    for (int i = 0; i < 6; i++) step(1'b1, 4'h7, "nop_seq");

    // ADD interrupted by reset during T5: immediate idle without a clock edge.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'h1, "add_pre_rst");
    run = 1'b1;
    ir_opcode = 4'h1;
    #1;
    check("add_t5_before_rst");
    #1;
    rst_n = 1'b0;
    m_step = 0;
    #1;
    check("async_rst_t5");
    n_cmp++;
    assert (b_load === 1'b0) else begin
      n_bad++;
      $error("FAIL async_rst_b_load: observed %b expected 0", b_load);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // HLT: halt after T4, stays halted through 20 cycles of toggling run.
    for (int i = 0; i < 5; i++) step(1'b1, 4'hF, "hlt_seq");
    for (int i = 0; i < 20; i++) step(1'(i % 2), 4'($urandom_range(0, 15)), "halt_hold");

    // Random traffic; recover from halt via reset.
    do_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      step(($urandom_range(0, 3) != 0), op, "random");
      if (m_step == 7 && $urandom_range(0, 3) == 0) do_reset(1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port run  input  1  high permits instruction execution; low parks sequencer in IDLE.
REQ-004 SHALL have port ir_opcode  input  4  upper nibble of instruction register; valid from T4 onward.
REQ-005 SHALL have ports pc_send, pc_inc  output  1 each  program counter drives bus / increments.
REQ-006 SHALL have ports mar_load, mem_send  output  1 each  address register load / memory drives bus.
REQ-007 SHALL have ports ir_load, ir_send  output  1 each  instruction register load / operand nibble drives bus.
REQ-008 SHALL have ports a_load, a_send, b_load  output  1 each  load and send strobes for A and B registers.
REQ-009 SHALL have ports alu_send  output  1  and alu_op  output  4  ALU result drives bus / ALU operation code.
REQ-010 SHALL have ports out_load  output  1  and halted  output  1  output register load / halt indicator.

Function
REQ-011 SHALL implement states IDLE, T1, T2, T3, T4, T5, T6, HALT, registered on clk.
REQ-012 SHALL move IDLE->T1 on a clk edge with run=1 and stay in IDLE while run=0.
REQ-013 SHALL step T1->T2->...->T6 one state per clock, independent of run.
REQ-014 SHALL move T6->T1 if run=1, else T6->IDLE; a run drop mid-instruction finishes the current instruction.
REQ-015 SHALL decode all outputs combinationally from state and ir_opcode (Moore per state, no added latency).
REQ-016 SHALL assert in fetch: T1 pc_send+mar_load; T2 pc_inc; T3 mem_send+ir_load.
REQ-017 SHALL for LDA (0x0): T4 ir_send+mar_load; T5 mem_send+a_load; T6 none.
REQ-018 SHALL for ADD (0x1): T4 ir_send+mar_load; T5 mem_send+b_load; T6 alu_send+a_load with alu_op=0000.
REQ-019 SHALL for OUT (0xE): T4 a_send+out_load; T5, T6 none.
REQ-020 SHALL for HLT (0xF): assert no strobes in T4 and move T4->HALT.
REQ-021 SHALL in HALT hold all strobes low and halted=1 regardless of run, leaving only by reset.
REQ-022 SHALL treat any undefined opcode as NOP: no strobes in T4-T6, normal T6 transition.
REQ-023 SHALL assert at most one *_send strobe (pc_send, mem_send, ir_send, a_send, alu_send) in any cycle.
REQ-024 SHALL drive alu_op=0000 in every cycle not covered by REQ-018 or REQ-028.
REQ-025 SHALL take exactly 6 clocks per non-HLT instruction and 4 clocks from T1 to HALT for HLT.

Reset
REQ-026 SHALL on rst_n=0 enter IDLE immediately, independent of clk, including mid-instruction.
REQ-027 SHALL drive all strobes 0, alu_op=0000 and halted=0 while in reset and in IDLE.

Configuration
REQ-028 SHALL with macro CTRL_SUB_EN defined decode SUB (0x2) exactly as ADD but with alu_op=0001 in T6.
REQ-029 SHALL without CTRL_SUB_EN defined treat opcode 0x2 as NOP per REQ-022.

Verification
REQ-030 SHALL cover: rst_n low, run=1, release -> IDLE for 0 cycles with run held, then T1 on first edge; pc_send=1, mar_load=1.
REQ-031 SHALL cover: ir_opcode=0x1, run=1 -> strobe sequence of REQ-016/018 over exactly 6 clocks; T6 alu_send=1, a_load=1, alu_op=0000.
REQ-032 SHALL cover: ir_opcode=0xF -> HALT after T4; halted=1 held 20 cycles with run toggling; all strobes 0.
REQ-033 SHALL cover: run dropped during T3 of LDA (0x0) -> T4-T6 complete normally, then IDLE; no T1.
REQ-034 SHALL cover: rst_n pulsed low during T5 of ADD -> immediate IDLE, b_load=0 without a clk edge.
REQ-035 SHALL cover: ir_opcode=0x2 -> T6 alu_op=0001 with CTRL_SUB_EN, no strobes T4-T6 without it; one-hot *_send checked every cycle.
